// File: rtl/div_reservation_station.sv
// Reservation station feeding div_unit: collects operands from dispatch and the CDB, issues
// complete entries in index order. Define DIV_RS_CDB_BYPASS_EN to issue CDB-completed entries same-cycle.

package div_rs_pkg;
    typedef struct packed {
        logic is_signed;
        logic is_extended;
        logic is_word;
        logic set_ov;
        logic set_cr0;
    } div_decode_t;
endpackage

module div_reservation_station
    import div_rs_pkg::*;
#(
    parameter int unsigned RS_ID_WIDTH = 5,
    parameter int unsigned RS_OFFSET   = 0,
    parameter int unsigned ENTRIES     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dispatch_valid,
    output logic                   dispatch_ready,
    output logic [RS_ID_WIDTH-1:0] dispatch_rs_id,
    input  logic [4:0]             result_reg_addr_in,
    input  div_decode_t            control_in,
    input  logic [31:0]            op1_in,
    input  logic [31:0]            op2_in,
    input  logic [31:0]            xer_in,
    input  logic                   op1_valid_in,
    input  logic                   op2_valid_in,
    input  logic                   xer_valid_in,
    input  logic [RS_ID_WIDTH-1:0] op1_tag_in,
    input  logic [RS_ID_WIDTH-1:0] op2_tag_in,
    input  logic [RS_ID_WIDTH-1:0] xer_tag_in,
    input  logic                   cdb_valid,
    input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
    input  logic [31:0]            cdb_result,
    input  logic [31:0]            cdb_xer,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [RS_ID_WIDTH-1:0] rs_id_out,
    output logic [4:0]             result_reg_addr_out,
    output logic [31:0]            op1_out,
    output logic [31:0]            op2_out,
    output logic [31:0]            xer_out,
    output div_decode_t            control_out
);

    localparam int unsigned IdxW   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    // Operand slots: 0 = op1, 1 = op2, 2 = xer.
    localparam int unsigned NumOps = 3;

    typedef enum logic [1:0] {StFree, StWaiting, StReady} slot_state_e;

    slot_state_e            state_q [ENTRIES];
    slot_state_e            state_d [ENTRIES];
    logic [31:0]            val_q   [ENTRIES][NumOps];
    logic [31:0]            val_d   [ENTRIES][NumOps];
    logic [RS_ID_WIDTH-1:0] tag_q   [ENTRIES][NumOps];
    logic [RS_ID_WIDTH-1:0] tag_d   [ENTRIES][NumOps];
    logic [NumOps-1:0]      vld_q   [ENTRIES];
    logic [NumOps-1:0]      vld_d   [ENTRIES];
    logic [4:0]             rd_q    [ENTRIES];
    logic [4:0]             rd_d    [ENTRIES];
    div_decode_t            ctrl_q  [ENTRIES];
    div_decode_t            ctrl_d  [ENTRIES];
    logic                   hold_q;
    logic                   hold_d;
    logic [IdxW-1:0]        hold_idx_q;
    logic [IdxW-1:0]        hold_idx_d;

    logic [31:0]            in_val    [NumOps];
    logic [RS_ID_WIDTH-1:0] in_tag    [NumOps];
    logic [NumOps-1:0]      in_vld;
    logic [NumOps-1:0]      in_hit;
    logic [31:0]            cdb_val   [NumOps];
    logic [NumOps-1:0]      snoop_hit [ENTRIES];

    logic                   free_found;
    logic [IdxW-1:0]        free_idx;
    logic                   rdy_found;
    logic [IdxW-1:0]        rdy_idx;
    logic                   sel_valid;
    logic [IdxW-1:0]        sel_idx;
    logic                   dispatch_fire;
    logic                   issue_fire;

    function automatic logic [RS_ID_WIDTH-1:0] slot_tag(input logic [IdxW-1:0] idx);
        return RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(idx);
    endfunction

    always_comb begin
        in_val[0]  = op1_in;
        in_val[1]  = op2_in;
        in_val[2]  = xer_in;
        in_tag[0]  = op1_tag_in;
        in_tag[1]  = op2_tag_in;
        in_tag[2]  = xer_tag_in;
        in_vld     = {xer_valid_in, op2_valid_in, op1_valid_in};
        cdb_val[0] = cdb_result;
        cdb_val[1] = cdb_result;
        cdb_val[2] = cdb_xer;
    end

    // Lowest free / lowest ready scans and per-entry CDB tag matching, all from registered state.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        rdy_found  = 1'b0;
        rdy_idx    = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!free_found && state_q[i] == StFree) begin
                free_found = 1'b1;
                free_idx   = IdxW'(i);
            end
            if (!rdy_found && state_q[i] == StReady) begin
                rdy_found = 1'b1;
                rdy_idx   = IdxW'(i);
            end
            snoop_hit[i] = '0;
            for (int unsigned k = 0; k < NumOps; k++) begin
                snoop_hit[i][k] = cdb_valid && state_q[i] == StWaiting && !vld_q[i][k] &&
                                  tag_q[i][k] == cdb_rs_id && cdb_rs_id != slot_tag(IdxW'(i));
            end
        end
    end

    assign dispatch_ready = free_found;
    assign dispatch_rs_id = free_found ? slot_tag(free_idx) : '0;
    assign dispatch_fire  = dispatch_valid && free_found;

    always_comb begin
        in_hit = '0;
        for (int unsigned k = 0; k < NumOps; k++) begin
            in_hit[k] = cdb_valid && !in_vld[k] && in_tag[k] == cdb_rs_id &&
                        cdb_rs_id != slot_tag(free_idx);
        end
    end

    // A stalled selection is pinned until accepted, so the outputs cannot change under div_unit.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        if (hold_q) begin
            sel_valid = 1'b1;
            sel_idx   = hold_idx_q;
        end else if (rdy_found) begin
            sel_valid = 1'b1;
            sel_idx   = rdy_idx;
        end
`ifdef DIV_RS_CDB_BYPASS_EN
        else begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (!sel_valid && state_q[i] == StWaiting && (&(vld_q[i] | snoop_hit[i]))) begin
                    sel_valid = 1'b1;
                    sel_idx   = IdxW'(i);
                end
            end
        end
`endif
    end

    assign issue_fire = sel_valid && issue_ready;
    assign hold_d     = sel_valid && !issue_ready;
    assign hold_idx_d = sel_idx;

    // Only a bypassed selection has invalid operands, and those are on the CDB right now.
    always_comb begin
        issue_valid         = sel_valid;
        rs_id_out           = '0;
        result_reg_addr_out = '0;
        op1_out             = '0;
        op2_out             = '0;
        xer_out             = '0;
        control_out         = '0;
        if (sel_valid) begin
            rs_id_out           = slot_tag(sel_idx);
            result_reg_addr_out = rd_q[sel_idx];
            op1_out             = vld_q[sel_idx][0] ? val_q[sel_idx][0] : cdb_val[0];
            op2_out             = vld_q[sel_idx][1] ? val_q[sel_idx][1] : cdb_val[1];
            xer_out             = vld_q[sel_idx][2] ? val_q[sel_idx][2] : cdb_val[2];
            control_out         = ctrl_q[sel_idx];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            state_d[i] = state_q[i];
            vld_d[i]   = vld_q[i];
            rd_d[i]    = rd_q[i];
            ctrl_d[i]  = ctrl_q[i];
            for (int unsigned k = 0; k < NumOps; k++) begin
                val_d[i][k] = val_q[i][k];
                tag_d[i][k] = tag_q[i][k];
                if (snoop_hit[i][k]) begin
                    val_d[i][k] = cdb_val[k];
                    vld_d[i][k] = 1'b1;
                end
            end
            if (state_q[i] == StWaiting && (&vld_d[i])) begin
                state_d[i] = StReady;
            end
            if (issue_fire && sel_idx == IdxW'(i)) begin
                state_d[i] = StFree;
                vld_d[i]   = '0;
            end
            // Dispatch only targets a pre-edge free slot, so it never collides with issue.
            if (dispatch_fire && free_idx == IdxW'(i)) begin
                for (int unsigned k = 0; k < NumOps; k++) begin
                    val_d[i][k] = in_hit[k] ? cdb_val[k] : in_val[k];
                    tag_d[i][k] = in_tag[k];
                end
                vld_d[i]   = in_vld | in_hit;
                rd_d[i]    = result_reg_addr_in;
                ctrl_d[i]  = control_in;
                state_d[i] = (&(in_vld | in_hit)) ? StReady : StWaiting;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                state_q[i] <= StFree;
                vld_q[i]   <= '0;
                rd_q[i]    <= '0;
                ctrl_q[i]  <= '0;
                for (int unsigned k = 0; k < NumOps; k++) begin
                    val_q[i][k] <= '0;
                    tag_q[i][k] <= '0;
                end
            end
        end else begin
            hold_q     <= hold_d;
            hold_idx_q <= hold_idx_d;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                state_q[i] <= state_d[i];
                vld_q[i]   <= vld_d[i];
                rd_q[i]    <= rd_d[i];
                ctrl_q[i]  <= ctrl_d[i];
                for (int unsigned k = 0; k < NumOps; k++) begin
                    val_q[i][k] <= val_d[i][k];
                    tag_q[i][k] <= tag_d[i][k];
                end
            end
        end
    end

endmodule

// File: tb/tb_div_reservation_station.sv
// Directed bench for div_reservation_station: expected issues are queued by the stimulus and
// popped by a negedge monitor on every issue handshake; timing/state checks are inline.

module tb_div_reservation_station;
    import div_rs_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        dispatch_valid;
    logic        dispatch_ready;
    logic [4:0]  dispatch_rs_id;
    logic [4:0]  result_reg_addr_in;
    div_decode_t control_in;
    logic [31:0] op1_in, op2_in, xer_in;
    logic        op1_valid_in, op2_valid_in, xer_valid_in;
    logic [4:0]  op1_tag_in, op2_tag_in, xer_tag_in;
    logic        cdb_valid;
    logic [4:0]  cdb_rs_id;
    logic [31:0] cdb_result, cdb_xer;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  rs_id_out;
    logic [4:0]  result_reg_addr_out;
    logic [31:0] op1_out, op2_out, xer_out;
    div_decode_t control_out;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] x;
        div_decode_t c;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    div_reservation_station #(
        .RS_ID_WIDTH(5),
        .RS_OFFSET  (0),
        .ENTRIES    (2)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .dispatch_valid     (dispatch_valid),
        .dispatch_ready     (dispatch_ready),
        .dispatch_rs_id     (dispatch_rs_id),
        .result_reg_addr_in (result_reg_addr_in),
        .control_in         (control_in),
        .op1_in             (op1_in),
        .op2_in             (op2_in),
        .xer_in             (xer_in),
        .op1_valid_in       (op1_valid_in),
        .op2_valid_in       (op2_valid_in),
        .xer_valid_in       (xer_valid_in),
        .op1_tag_in         (op1_tag_in),
        .op2_tag_in         (op2_tag_in),
        .xer_tag_in         (xer_tag_in),
        .cdb_valid          (cdb_valid),
        .cdb_rs_id          (cdb_rs_id),
        .cdb_result         (cdb_result),
        .cdb_xer            (cdb_xer),
        .issue_valid        (issue_valid),
        .issue_ready        (issue_ready),
        .rs_id_out          (rs_id_out),
        .result_reg_addr_out(result_reg_addr_out),
        .op1_out            (op1_out),
        .op2_out            (op2_out),
        .xer_out            (xer_out),
        .control_out        (control_out)
    );

    always #5 clk = ~clk;

    function automatic div_decode_t ctl(input logic [4:0] rd);
        return div_decode_t'(rd ^ 5'h15);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [4:0] rs, input logic [4:0] rd, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] x);
        exp_t e;
        e.rs = rs;
        e.rd = rd;
        e.a  = a;
        e.b  = b;
        e.x  = x;
        e.c  = ctl(rd);
        exp_q.push_back(e);
    endtask

    task automatic dispatch(input logic [4:0] rd,
                            input logic [31:0] a, input logic av, input logic [4:0] at,
                            input logic [31:0] b, input logic bv, input logic [4:0] bt,
                            input logic [31:0] x, input logic xv, input logic [4:0] xt);
        result_reg_addr_in = rd;
        control_in         = ctl(rd);
        op1_in = a;  op1_valid_in = av;  op1_tag_in = at;
        op2_in = b;  op2_valid_in = bv;  op2_tag_in = bt;
        xer_in = x;  xer_valid_in = xv;  xer_tag_in = xt;
        dispatch_valid = 1'b1;
        tick();
        dispatch_valid = 1'b0;
    endtask

    // Scoreboard monitor: every accepted issue must match the next queued expectation.
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        if (!rst && issue_valid && issue_ready) begin
            got = {rs_id_out, result_reg_addr_out, op1_out, op2_out, xer_out, control_out};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got %h, required no issue", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL issue_payload: got %h, required %h", got, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        dispatch_valid = 1'b0;
        result_reg_addr_in = '0;
        control_in = '0;
        op1_in = '0; op2_in = '0; xer_in = '0;
        op1_valid_in = 1'b0; op2_valid_in = 1'b0; xer_valid_in = 1'b0;
        op1_tag_in = '0; op2_tag_in = '0; xer_tag_in = '0;
        cdb_valid = 1'b0; cdb_rs_id = '0; cdb_result = '0; cdb_xer = '0;
        issue_ready = 1'b0;
        #2;
        check("rst_issue_valid", 32'(issue_valid), 0);
        check("rst_dispatch_ready", 32'(dispatch_ready), 1);
        check("rst_dispatch_rs_id", 32'(dispatch_rs_id), 0);
        check("rst_op1_out", op1_out, 0);
        check("rst_xer_out", xer_out, 0);
        tick();
        tick();
        rst = 1'b0;

        // All-valid dispatch issues the next cycle as tag 0.
        issue_ready = 1'b1;
        push_exp(5'd0, 5'd3, 32'd100, 32'd7, 32'd0);
        dispatch(5'd3, 32'd100, 1'b1, 5'd0, 32'd7, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0);
        check("t1_issue_valid", 32'(issue_valid), 1);
        check("t1_rs_id_out", 32'(rs_id_out), 0);
        check("t1_op1_out", op1_out, 100);
        check("t1_op2_out", op2_out, 7);
        tick();
        check("t1_freed_issue_valid", 32'(issue_valid), 0);
        check("t1_freed_dispatch_rs_id", 32'(dispatch_rs_id), 0);

        // op2 waits on tag 9, delivered by the CDB three cycles later.
        push_exp(5'd0, 5'd4, 32'd20, 32'd5, 32'd0);
        dispatch(5'd4, 32'd20, 1'b1, 5'd0, 32'd0, 1'b0, 5'd9, 32'd0, 1'b1, 5'd0);
        for (int c = 0; c < 3; c++) begin
            check("t2_waiting_issue_valid", 32'(issue_valid), 0);
            tick();
        end
        cdb_valid = 1'b1; cdb_rs_id = 5'd9; cdb_result = 32'd5; cdb_xer = 32'hffff;
        #1;
`ifdef DIV_RS_CDB_BYPASS_EN
        check("t2_bypass_issue_valid", 32'(issue_valid), 1);
        check("t2_bypass_op2_out", op2_out, 5);
`else
        check("t2_bcast_cycle_issue_valid", 32'(issue_valid), 0);
`endif
        tick();
        cdb_valid = 1'b0;
`ifdef DIV_RS_CDB_BYPASS_EN
        check("t2_after_bypass_issue_valid", 32'(issue_valid), 0);
`else
        check("t2_next_issue_valid", 32'(issue_valid), 1);
        check("t2_next_op2_out", op2_out, 5);
        check("t2_next_xer_out", xer_out, 0);
`endif
        tick();
        check("t2_drained_issue_valid", 32'(issue_valid), 0);

        // Fill both entries with issue stalled; a third dispatch must be ignored.
        issue_ready = 1'b0;
        dispatch(5'd5, 32'd11, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0);
        check("t3_next_rs_id", 32'(dispatch_rs_id), 1);
        dispatch(5'd6, 32'd22, 1'b1, 5'd0, 32'd2, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0);
        check("t3_full_dispatch_ready", 32'(dispatch_ready), 0);
        dispatch(5'd10, 32'd33, 1'b1, 5'd0, 32'd3, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0);
        check("t3_still_full", 32'(dispatch_ready), 0);
        check("t3_stall_rs_id", 32'(rs_id_out), 0);
        check("t3_stall_op1", op1_out, 11);
        tick();
        check("t3_stall2_rs_id", 32'(rs_id_out), 0);
        check("t3_stall2_op1", op1_out, 11);
        push_exp(5'd0, 5'd5, 32'd11, 32'd1, 32'd0);
        push_exp(5'd1, 5'd6, 32'd22, 32'd2, 32'd0);
        issue_ready = 1'b1;
        tick();
        check("t3_second_rs_id", 32'(rs_id_out), 1);
        check("t3_second_op1", op1_out, 22);
        tick();
        check("t3_empty_issue_valid", 32'(issue_valid), 0);
        check("t3_empty_dispatch_ready", 32'(dispatch_ready), 1);

        // xer tag 3 broadcast in the same cycle as the dispatch.
        push_exp(5'd0, 5'd7, 32'd50, 32'd3, 32'h8000_0000);
        cdb_valid = 1'b1; cdb_rs_id = 5'd3; cdb_result = 32'hdead; cdb_xer = 32'h8000_0000;
        dispatch(5'd7, 32'd50, 1'b1, 5'd0, 32'd3, 1'b1, 5'd0, 32'd0, 1'b0, 5'd3);
        cdb_valid = 1'b0;
        check("t4_issue_valid", 32'(issue_valid), 1);
        check("t4_xer_out", xer_out, 32'h8000_0000);
        tick();
        check("t4_drained", 32'(issue_valid), 0);

        // Asynchronous reset with two READY entries.
        issue_ready = 1'b0;
        dispatch(5'd1, 32'd1, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0);
        dispatch(5'd2, 32'd2, 1'b1, 5'd0, 32'd2, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0);
        check("t5_pre_issue_valid", 32'(issue_valid), 1);
        #3;
        rst = 1'b1;
        #1;
        check("t5_async_issue_valid", 32'(issue_valid), 0);
        check("t5_async_dispatch_ready", 32'(dispatch_ready), 1);
        check("t5_async_op1_out", op1_out, 0);
        tick();
        rst = 1'b0;
        issue_ready = 1'b1;
        #1;
        check("t5_deassert_issue_valid", 32'(issue_valid), 0);
        tick();
        check("t5_first_cycle_issue_valid", 32'(issue_valid), 0);

        // Entry 1 stalled; entry 0 completing via CDB must not steal the selection.
        issue_ready = 1'b0;
        dispatch(5'd8, 32'd0, 1'b0, 5'd12, 32'd4, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0);
        dispatch(5'd9, 32'd60, 1'b1, 5'd0, 32'd6, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0);
        check("t6_sel_entry1", 32'(rs_id_out), 1);
        cdb_valid = 1'b1; cdb_rs_id = 5'd12; cdb_result = 32'd120; cdb_xer = 32'd0;
        #1;
        check("t6_bcast_rs_id", 32'(rs_id_out), 1);
        tick();
        cdb_valid = 1'b0;
        check("t6_hold_rs_id", 32'(rs_id_out), 1);
        check("t6_hold_op1", op1_out, 60);
        tick();
        check("t6_hold2_rs_id", 32'(rs_id_out), 1);
        push_exp(5'd1, 5'd9, 32'd60, 32'd6, 32'd0);
        push_exp(5'd0, 5'd8, 32'd120, 32'd4, 32'd0);
        issue_ready = 1'b1;
        tick();
        check("t6_then_rs_id", 32'(rs_id_out), 0);
        check("t6_then_op1", op1_out, 120);
        tick();
        check("t6_drained", 32'(issue_valid), 0);

        // A broadcast of an entry's own tag must not fill that entry.
        cdb_valid = 1'b1; cdb_rs_id = 5'd0; cdb_result = 32'd77; cdb_xer = 32'd0;
        dispatch(5'd11, 32'd0, 1'b0, 5'd0, 32'd1, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0);
        check("t7_own_tag_issue_valid", 32'(issue_valid), 0);
        tick();
        cdb_valid = 1'b0;
        check("t7_own_tag_issue_valid2", 32'(issue_valid), 0);
        check("t7_own_tag_next_free", 32'(dispatch_rs_id), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("t7_cleared_ready", 32'(dispatch_ready), 1);

        check("scoreboard_leftover", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
